ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter; the send direction of the keyboard receiver.

---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_line_sync.sv | 38 +++
 rtl/ps2_host_tx.sv | 236 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ps2_pkg : shared PS/2 host-transmitter types and constants       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_START     = 3'd2,
      ST_SHIFT     = 3'd3,
      ST_WAIT_ACK  = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } ps2_state_e;

   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_ERR  = 2;
   localparam int STAT_NACK = 3;
   localparam int STAT_OVR  = 4;

   localparam logic [3:0] DATA_BITS   = 4'd8;
   localparam logic [3:0] PARITY_EDGE = 4'd9;
   localparam logic [3:0] STOP_EDGE   = 4'd10;

   localparam logic [31:0] REG_DATA   = 32'h0;
   localparam logic [31:0] REG_STATUS = 32'h4;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ps2_line_sync : 2-FF synchronizer for PS2C/PS2D + PS2C fall pulse |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ps2_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic ps2c_i,
   input  logic ps2d_i,
   output logic ps2c_o,
   output logic ps2d_o,
   output logic ps2c_fall_o
);

   logic [1:0] c_ff_q;
   logic [1:0] d_ff_q;
   logic       c_prev_q;

   // Idle lines are high, so reset to 1 to avoid a spurious edge on release.
   always_ff @(posedge clk) begin
      if (rst) begin
         c_ff_q   <= 2'b11;
         d_ff_q   <= 2'b11;
         c_prev_q <= 1'b1;
      end else begin
         c_ff_q   <= {c_ff_q[0], ps2c_i};
         d_ff_q   <= {d_ff_q[0], ps2d_i};
         c_prev_q <= c_ff_q[1];
      end
   end

   assign ps2c_o      = c_ff_q[1];
   assign ps2d_o      = d_ff_q[1];
   assign ps2c_fall_o = c_prev_q & ~c_ff_q[1];

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ps2_host_tx : Wishbone host-to-device PS/2 command transmitter   |
// | Optional watchdog: define PS2_TX_TIMEOUT_EN                      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned INHIBIT_US = 100,
   parameter int unsigned TIMEOUT_MS = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        STB,
   input  logic        WE,
   input  logic [31:0] ADDR,
   input  logic [31:0] DAT_I,
   output logic [31:0] DAT_O,
   output logic        ACK,
   output logic        INT,
   input  logic        ps2c_i,
   input  logic        ps2d_i,
   output logic        ps2c_oe,
   output logic        ps2d_oe
);

   localparam logic [31:0] INHIBIT_CYC =
      32'(64'(INHIBIT_US) * 64'(CLK_HZ) / 64'd1_000_000);
   localparam logic [31:0] TIMEOUT_CYC =
      32'(64'(TIMEOUT_MS) * 64'(CLK_HZ) / 64'd1_000);

   ps2_state_e  state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [3:0]  bitcnt_q, bitcnt_d, bitnext;
   logic [7:0]  byte_q, byte_d;
   logic        par_q, par_d;
   logic        c_oe_q, c_oe_d, d_oe_q, d_oe_d;
   logic        fnack_q, fnack_d;
   logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic        nack_q, nack_d, ovr_q, ovr_d;
   logic        stb_q, ack_q, ack_d;
   logic [31:0] dat_q, dat_d, status;
   logic        c_s, d_s, c_fall;
   logic        bus_acc, wr_data, rd_status;
   logic        unused_bits;

   ps2_line_sync u_sync (
      .clk         (clk),
      .rst         (rst),
      .ps2c_i      (ps2c_i),
      .ps2d_i      (ps2d_i),
      .ps2c_o      (c_s),
      .ps2d_o      (d_s),
      .ps2c_fall_o (c_fall)
   );

   assign bus_acc   = STB & ~stb_q;
   assign wr_data   = bus_acc & WE & (ADDR[2] == REG_DATA[2]);
   assign rd_status = bus_acc & ~WE & (ADDR[2] == REG_STATUS[2]);
   assign bitnext   = bitcnt_q + 4'd1;

   always_comb begin
      status            = '0;
      status[STAT_BUSY] = busy_q;
      status[STAT_DONE] = done_q;
      status[STAT_ERR]  = err_q;
      status[STAT_NACK] = nack_q;
      status[STAT_OVR]  = ovr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         bitcnt_q <= '0;
         byte_q   <= '0;
         par_q    <= 1'b0;
         c_oe_q   <= 1'b0;
         d_oe_q   <= 1'b0;
         fnack_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         nack_q   <= 1'b0;
         ovr_q    <= 1'b0;
         stb_q    <= 1'b0;
         ack_q    <= 1'b0;
         dat_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bitcnt_q <= bitcnt_d;
         byte_q   <= byte_d;
         par_q    <= par_d;
         c_oe_q   <= c_oe_d;
         d_oe_q   <= d_oe_d;
         fnack_q  <= fnack_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         nack_q   <= nack_d;
         ovr_q    <= ovr_d;
         stb_q    <= STB;
         ack_q    <= ack_d;
         dat_q    <= dat_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bitcnt_d = bitcnt_q;
      byte_d   = byte_q;
      par_d    = par_q;
      c_oe_d   = c_oe_q;
      d_oe_d   = d_oe_q;
      fnack_d  = fnack_q;
      busy_d   = busy_q;
      done_d   = done_q;
      err_d    = err_q;
      nack_d   = nack_q;
      ovr_d    = ovr_q;
      ack_d    = bus_acc;
      dat_d    = '0;

      // Clears come first so a same-cycle completion below overrides them.
      if (rd_status) begin
         dat_d  = status;
         done_d = 1'b0;
         err_d  = 1'b0;
         nack_d = 1'b0;
         ovr_d  = 1'b0;
      end else if (bus_acc && !WE) begin
         dat_d = {24'b0, byte_q};
      end
      if (wr_data && state_q != ST_IDLE) begin
         ovr_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            c_oe_d = 1'b0;
            d_oe_d = 1'b0;
            if (wr_data) begin
               byte_d  = DAT_I[7:0];
               par_d   = odd_parity(DAT_I[7:0]);
               busy_d  = 1'b1;
               fnack_d = 1'b0;
               cnt_d   = '0;
               c_oe_d  = 1'b1;
               state_d = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (cnt_q == INHIBIT_CYC - 32'd1) begin
               cnt_d   = '0;
               d_oe_d  = 1'b1;
               state_d = ST_START;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         ST_START: begin
            c_oe_d   = 1'b0;
            bitcnt_d = '0;
            cnt_d    = '0;
            state_d  = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (c_fall) begin
               bitcnt_d = bitnext;
               cnt_d    = '0;
               // Edge n (1..8) carries data bit n-1, which is the old count.
               if (bitnext <= DATA_BITS) begin
                  d_oe_d = ~byte_q[bitcnt_q[2:0]];
               end else if (bitnext == PARITY_EDGE) begin
                  d_oe_d = ~par_q;
               end else if (bitnext == STOP_EDGE) begin
                  d_oe_d  = 1'b0;
                  state_d = ST_WAIT_ACK;
               end
            end
         end
         ST_WAIT_ACK: begin
            if (c_fall) begin
               cnt_d = '0;
               if (d_s) begin
                  fnack_d = 1'b1;
                  nack_d  = 1'b1;
                  err_d   = 1'b1;
               end
               state_d = ST_WAIT_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            if (c_s && d_s) begin
               busy_d  = 1'b0;
               done_d  = done_q | ~fnack_q;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            c_oe_d  = 1'b0;
            d_oe_d  = 1'b0;
         end
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      if ((state_q == ST_SHIFT || state_q == ST_WAIT_ACK) && !c_fall) begin
         if (cnt_q == TIMEOUT_CYC - 32'd1) begin
            state_d = ST_IDLE;
            c_oe_d  = 1'b0;
            d_oe_d  = 1'b0;
            err_d   = 1'b1;
            nack_d  = 1'b0;
            busy_d  = 1'b0;
         end else begin
            cnt_d = cnt_q + 32'd1;
         end
      end
`endif
   end

   assign DAT_O   = dat_q;
   assign ACK     = ack_q;
   assign INT     = done_q | err_q;
   assign ps2c_oe = c_oe_q;
   assign ps2d_oe = d_oe_q;

   assign unused_bits = ^{ADDR[31:3], ADDR[1:0], DAT_I[31:8], TIMEOUT_CYC};

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ps2_host_tx : directed bench with a behavioural PS/2 device    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_ps2_host_tx;

   localparam int HALF = 25;

   logic        clk, rst, STB, WE, ACK, INT, ps2c_oe, ps2d_oe;
   logic [31:0] ADDR, DAT_I, DAT_O;
   logic        dev_c_low, dev_d_low;
   wire         ps2c_line = ~(ps2c_oe | dev_c_low);
   wire         ps2d_line = ~(ps2d_oe | dev_d_low);

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int wr_cyc = 0;

   ps2_host_tx dut (
      .clk     (clk),
      .rst     (rst),
      .STB     (STB),
      .WE      (WE),
      .ADDR    (ADDR),
      .DAT_I   (DAT_I),
      .DAT_O   (DAT_O),
      .ACK     (ACK),
      .INT     (INT),
      .ps2c_i  (ps2c_line),
      .ps2d_i  (ps2d_line),
      .ps2c_oe (ps2c_oe),
      .ps2d_oe (ps2d_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic bus_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input int hold, output logic [31:0] rd, output int acks,
                           output int first);
      acks  = 0;
      first = -1;
      rd    = '0;
      @(posedge clk);
      #1 STB = 1'b1; WE = we; ADDR = addr; DAT_I = wd;
      for (int i = 0; i < hold + 3; i++) begin
         @(negedge clk);
         if (ACK === 1'b1) begin
            acks++;
            if (first < 0) begin
               first = i;
               rd    = DAT_O;
               if (we) wr_cyc = cyc;
            end
         end
         if (i == hold - 1) begin
            @(posedge clk);
            #1 STB = 1'b0; WE = 1'b0;
         end
      end
   endtask

   task automatic wr_data(input logic [7:0] b);
      logic [31:0] rd;
      int          acks, first;
      bus_xfer(1'b1, 32'h0, {24'b0, b}, 2, rd, acks, first);
   endtask

   task automatic rd_status(input string tag, input logic [31:0] exp);
      logic [31:0] rd;
      int          acks, first;
      bus_xfer(1'b0, 32'h4, 32'h0, 2, rd, acks, first);
      chk(tag, rd, exp);
   endtask

   task automatic wait_int(input int max);
      int t = 0;
      while (INT !== 1'b1 && t < max) begin
         @(negedge clk);
         t++;
      end
   endtask

   // Device model: measures inhibit, clocks 11 bits, samples PS2D on rising edges.
   task automatic dev_frame(input logic dev_ack, input int hook_edge, input int hook_kind,
                            output logic [7:0] d, output logic p, output logic stopb,
                            output int inh, output logic startb);
      logic [31:0] rd;
      int          acks, first, t;
      d = '0; p = 1'b0; stopb = 1'b0; startb = 1'b0; t = 0;
      while (ps2c_oe === 1'b1 && t < 20000) begin
         @(negedge clk);
         t++;
      end
      inh    = cyc - wr_cyc;
      startb = ps2d_oe;
      repeat (HALF) @(posedge clk);
      for (int e = 1; e <= 11; e++) begin
         #1 dev_c_low = 1'b1;
         if (e == hook_edge) begin
            repeat (6) @(posedge clk);
            if (hook_kind == 1) begin
               bus_xfer(1'b1, 32'h0, 32'h55, 2, rd, acks, first);
            end else begin
               @(negedge clk);
               chkb("pre_rst_d_oe", ps2d_oe, 1'b1);
               @(posedge clk);
               #1 rst = 1'b1;
               @(posedge clk);
               #1 rst = 1'b0;
               @(negedge clk);
               chkb("rst_mid_c_oe", ps2c_oe, 1'b0);
               chkb("rst_mid_d_oe", ps2d_oe, 1'b0);
               dev_c_low = 1'b0;
               dev_d_low = 1'b0;
               repeat (20) @(posedge clk);
               return;
            end
         end
         repeat (HALF) @(posedge clk);
         #1 dev_c_low = 1'b0;
         repeat (HALF / 2) @(posedge clk);
         if (e <= 8) begin
            d[e-1] = ps2d_line;
         end else if (e == 9) begin
            p = ps2d_line;
         end else if (e == 10) begin
            stopb = ps2d_line;
            if (dev_ack) dev_d_low = 1'b1;
         end else begin
            dev_d_low = 1'b0;
         end
         repeat (HALF - HALF / 2) @(posedge clk);
      end
   endtask

   initial begin
      logic [7:0]  d;
      logic        p, stopb, startb;
      int          inh, acks, first;
      logic [31:0] rd;

      rst = 1'b1; STB = 1'b0; WE = 1'b0; ADDR = '0; DAT_I = '0;
      dev_c_low = 1'b0; dev_d_low = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk ("rst_dat_o", DAT_O, 32'h0);
      chkb("rst_ack", ACK, 1'b0);
      chkb("rst_int", INT, 1'b0);
      chkb("rst_c_oe", ps2c_oe, 1'b0);
      chkb("rst_d_oe", ps2d_oe, 1'b0);
      rd_status("rst_status", 32'h0);

      // 0xED acknowledged by the device
      bus_xfer(1'b1, 32'h0, 32'hED, 2, rd, acks, first);
      chk("t1_wr_acks", acks, 1);
      chk("t1_wr_ackpos", first, 1);
      rd_status("t1_busy", 32'h01);
      dev_frame(1'b1, 0, 0, d, p, stopb, inh, startb);
      chk ("t1_inhibit", inh, 10001);
      chkb("t1_start", startb, 1'b1);
      chk ("t1_data", {24'b0, d}, 32'hED);
      chkb("t1_parity", p, 1'b1);
      chkb("t1_stop", stopb, 1'b1);
      wait_int(300);
      chkb("t1_int", INT, 1'b1);
      rd_status("t1_status", 32'h02);
      @(negedge clk);
      chkb("t1_int_clr", INT, 1'b0);

      // 0xFF, device leaves ACK bit high
      wr_data(8'hFF);
      dev_frame(1'b0, 0, 0, d, p, stopb, inh, startb);
      chk ("t2_data", {24'b0, d}, 32'hFF);
      chkb("t2_parity", p, 1'b1);
      repeat (50) @(posedge clk);
      @(negedge clk);
      chkb("t2_int", INT, 1'b1);
      rd_status("t2_status", 32'h0C);

      // 0x00 with an overrun write of 0x55 mid-frame
      wr_data(8'h00);
      dev_frame(1'b1, 3, 1, d, p, stopb, inh, startb);
      chk ("t3_data", {24'b0, d}, 32'h00);
      chkb("t3_parity", p, 1'b1);
      wait_int(300);
      rd_status("t3_status", 32'h12);
      @(negedge clk);
      chkb("t3_int_clr", INT, 1'b0);
      rd_status("t3_status_clr", 32'h00);

      // Long STB on a STATUS read, then reset mid-frame
      wr_data(8'h00);
      bus_xfer(1'b0, 32'h4, 32'h0, 5, rd, acks, first);
      chk("t4_acks", acks, 1);
      chk("t4_ackpos", first, 1);
      chk("t4_dat_o", rd, 32'h01);
      dev_frame(1'b1, 5, 2, d, p, stopb, inh, startb);
      rd_status("t5_status_rst", 32'h00);
      wr_data(8'hF4);
      dev_frame(1'b1, 0, 0, d, p, stopb, inh, startb);
      chk ("t5_inhibit", inh, 10001);
      chk ("t5_data", {24'b0, d}, 32'hF4);
      chkb("t5_parity", p, 1'b0);
      wait_int(300);
      rd_status("t5_status", 32'h02);

      // Silent device
      wr_data(8'hAB);
`ifdef PS2_TX_TIMEOUT_EN
      wait_int(1_600_000);
      chkb("t6_c_oe", ps2c_oe, 1'b0);
      chkb("t6_d_oe", ps2d_oe, 1'b0);
      rd_status("t6_status", 32'h04);
`else
      repeat (12000) @(posedge clk);
      @(negedge clk);
      chkb("t6_c_oe", ps2c_oe, 1'b0);
      chkb("t6_d_oe", ps2d_oe, 1'b1);
      chkb("t6_int", INT, 1'b0);
      rd_status("t6_status", 32'h01);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
